// File: rtl/counter_share_arbiter_if.sv
// Request/grant bundle between the client blocks and the shared interval counter.
// The arbiter takes the slave side; clients, or a bench, take the master side.
interface counter_share_arbiter_if #(
    parameter int NREQ = 4,
    parameter int CW   = 8
);
    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] len;
    logic [NREQ-1:0]    gnt;
    logic               busy;
    logic [CW-1:0]      count;
    logic [NREQ-1:0]    done;

    modport master (
        output req,
        output len,
        input  gnt,
        input  busy,
        input  count,
        input  done
    );

    modport slave (
        input  req,
        input  len,
        output gnt,
        output busy,
        output count,
        output done
    );
endinterface

// File: rtl/counter_share_arbiter.sv
// Round-robin arbiter that lends one down-counter to NREQ requesters.
// The owner gets a one-cycle done pulse when its interval has fully counted down.
module counter_share_arbiter #(
    parameter int NREQ = 4,
    parameter int CW   = 8
) (
    input logic                     clk,
    input logic                     rst_n,
    counter_share_arbiter_if.slave  bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state, next_state;
    logic [NREQ-1:0] gnt_q, next_gnt;
    logic [NREQ-1:0] done_q, next_done;
    logic [CW-1:0]   count_q, next_count;
    logic [PW-1:0]   last_q, next_last;
    logic            busy_q;

    logic [CW-1:0]   len_arr [NREQ];
    logic [PW-1:0]   winner;
    logic [PW-1:0]   cand;
    logic            found;

    for (genvar i = 0; i < NREQ; i++) begin : g_len
        assign len_arr[i] = bus.len[i*CW +: CW];
    end

    // Search starts just after the previous winner, so the last owner ranks lowest.
    always_comb begin
        found  = 1'b0;
        winner = last_q;
        cand   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = PW'((int'(last_q) + k) % NREQ);
            if (!found && bus.req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        next_state = state;
        next_gnt   = gnt_q;
        next_count = count_q;
        next_done  = '0;
        next_last  = last_q;
        case (state)
            IDLE: begin
                if (found) begin
                    next_state = RUN;
                    next_gnt   = NREQ'(1) << winner;
                    next_count = len_arr[winner];
                    next_last  = winner;
                end
            end
            RUN: begin
                // A dropped request wins over expiry: the owner no longer wants the pulse.
                if ((bus.req & gnt_q) == '0) begin
                    next_state = IDLE;
                    next_gnt   = '0;
                    next_count = '0;
                end else if (count_q == '0) begin
                    next_state = DONE;
                    next_done  = gnt_q;
                end else begin
                    next_count = count_q - CW'(1);
                end
            end
            DONE: begin
                next_state = IDLE;
                next_gnt   = '0;
            end
            default: begin
                next_state = IDLE;
                next_gnt   = '0;
                next_count = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            last_q  <= PW'(NREQ - 1);
        end else begin
            state   <= next_state;
            gnt_q   <= next_gnt;
            done_q  <= next_done;
            count_q <= next_count;
            busy_q  <= (next_state != IDLE);
            last_q  <= next_last;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.done  = done_q;
    assign bus.count = count_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_counter_share_arbiter.sv
// Bench for counter_share_arbiter: constant vector table, directed corner sequences,
// and random traffic checked against a timeline model of each grant.
module tb_counter_share_arbiter;
    localparam int NREQ = 4;
    localparam int CW   = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    counter_share_arbiter_if #(.NREQ(NREQ), .CW(CW)) bus ();

    counter_share_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Reference: owner index, its sampled length, and edges elapsed since its grant.
    int m_owner;
    int m_len;
    int m_age;
    int m_last;

    logic [CW-1:0] lens [NREQ];

    typedef struct {
        logic [NREQ-1:0] req;
        logic [CW-1:0]   len;
        logic [NREQ-1:0] gnt;
        logic            busy;
        logic [CW-1:0]   count;
        logic [NREQ-1:0] done;
    } vec_t;

    vec_t vecs [9];

    function automatic void modelReset();
        m_owner = -1;
        m_len   = 0;
        m_age   = 0;
        m_last  = NREQ - 1;
    endfunction

    // A grant of length L lives for edges 0..L counting, edge L+1 is the done cycle.
    function automatic void modelEdge();
        if (m_owner < 0) begin
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (m_last + k) % NREQ;
                if (bus.req[c]) begin
                    m_owner = c;
                    m_len   = int'(lens[c]);
                    m_age   = 0;
                    m_last  = c;
                    break;
                end
            end
        end else if (m_age <= m_len) begin
            if (!bus.req[m_owner]) m_owner = -1;
            else m_age++;
        end else begin
            m_owner = -1;
        end
    endfunction

    task automatic applyStimulus(input logic [NREQ-1:0] r);
        bus.req = r;
        for (int i = 0; i < NREQ; i++) bus.len[i*CW +: CW] = lens[i];
    endtask

    task automatic checkOutput(input string name, input logic [NREQ-1:0] g, input logic b,
                               input logic [CW-1:0] c, input logic [NREQ-1:0] d);
        checks++;
        if (bus.gnt === g && bus.busy === b && bus.count === c && bus.done === d) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got gnt=%b busy=%b count=%0d done=%b, expected gnt=%b busy=%b count=%0d done=%b",
                     name, bus.gnt, bus.busy, bus.count, bus.done, g, b, c, d);
        end
    endtask

    task automatic checkModel(input string name);
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] d;
        logic [CW-1:0]   c;
        logic            b;
        g = '0;
        d = '0;
        c = '0;
        b = 1'b0;
        if (m_owner >= 0) begin
            g = NREQ'(1) << m_owner;
            b = 1'b1;
            if (m_age <= m_len) c = CW'(m_len - m_age);
            else d = g;
        end
        checkOutput(name, g, b, c, d);
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        modelReset();
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int order [5];
        int ngrants;
        logic [NREQ-1:0] prev_gnt;

        vecs[0] = '{4'b0001, 8'd3, 4'b0001, 1'b1, 8'd3, 4'b0000};
        vecs[1] = '{4'b0001, 8'd3, 4'b0001, 1'b1, 8'd2, 4'b0000};
        vecs[2] = '{4'b0001, 8'd3, 4'b0001, 1'b1, 8'd1, 4'b0000};
        vecs[3] = '{4'b0001, 8'd3, 4'b0001, 1'b1, 8'd0, 4'b0000};
        vecs[4] = '{4'b0001, 8'd3, 4'b0001, 1'b1, 8'd0, 4'b0001};
        vecs[5] = '{4'b0000, 8'd3, 4'b0000, 1'b0, 8'd0, 4'b0000};
        vecs[6] = '{4'b0100, 8'd0, 4'b0100, 1'b1, 8'd0, 4'b0000};
        vecs[7] = '{4'b0100, 8'd0, 4'b0100, 1'b1, 8'd0, 4'b0100};
        vecs[8] = '{4'b0000, 8'd0, 4'b0000, 1'b0, 8'd0, 4'b0000};

        for (int i = 0; i < NREQ; i++) lens[i] = '0;
        modelReset();
        applyStimulus('0);
        #12;
        checkOutput("reset_state", '0, 1'b0, '0, '0);
        rst_n = 1'b1;

        // Single request with length 3, then a zero-length grant to requester 2.
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < NREQ; j++) lens[j] = vecs[i].len;
            applyStimulus(vecs[i].req);
            tick();
            checkOutput($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].busy, vecs[i].count, vecs[i].done);
            checkModel($sformatf("vec%0d_model", i));
        end

        // Round-robin with every requester held high.
        doReset();
        for (int j = 0; j < NREQ; j++) lens[j] = 8'd1;
        applyStimulus(4'b1111);
        ngrants  = 0;
        prev_gnt = '0;
        for (int cyc = 0; cyc < 40 && ngrants < 5; cyc++) begin
            tick();
            checkModel("rr_model");
            if (bus.gnt != '0 && prev_gnt == '0) begin
                for (int b = 0; b < NREQ; b++) if (bus.gnt[b]) order[ngrants] = b;
                ngrants++;
            end
            prev_gnt = bus.gnt;
        end
        checks++;
        if (ngrants == 5) passed++;
        else $display("[TB] FAIL rr_timeout: got %0d grants, expected 5", ngrants);
        for (int i = 0; i < ngrants; i++) begin
            checks++;
            if (order[i] == (i % NREQ)) passed++;
            else $display("[TB] FAIL rr_order%0d: got requester %0d, expected %0d", i, order[i], i % NREQ);
        end
        applyStimulus('0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkModel("rr_drain");
        end

        // Abandon mid-count; pointer must resume after the abandoned owner.
        doReset();
        for (int j = 0; j < NREQ; j++) lens[j] = 8'd4;
        lens[1] = 8'd10;
        applyStimulus(4'b0010);
        tick();
        checkOutput("abandon_grant", 4'b0010, 1'b1, 8'd10, '0);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("abandon_count6", 4'b0010, 1'b1, 8'd6, '0);
        applyStimulus(4'b0000);
        tick();
        checkOutput("abandon_idle", '0, 1'b0, '0, '0);
        applyStimulus(4'b1111);
        tick();
        checkOutput("abandon_next", 4'b0100, 1'b1, 8'd4, '0);
        checkModel("abandon_model");
        applyStimulus('0);
        tick();
        checkModel("abandon_drop");

        // Request drops on the very edge the count would expire.
        lens[0] = 8'd2;
        applyStimulus(4'b0001);
        tick();
        checkOutput("expire_grant", 4'b0001, 1'b1, 8'd2, '0);
        tick();
        tick();
        checkOutput("expire_zero", 4'b0001, 1'b1, 8'd0, '0);
        applyStimulus('0);
        tick();
        checkOutput("expire_abandon", '0, 1'b0, '0, '0);
        tick();
        checkOutput("expire_nodone", '0, 1'b0, '0, '0);

        // Asynchronous reset between edges in the middle of a count.
        lens[0] = 8'd9;
        lens[1] = 8'd4;
        applyStimulus(4'b0001);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("pre_reset", 4'b0001, 1'b1, 8'd5, '0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", '0, 1'b0, '0, '0);
        modelReset();
        applyStimulus(4'b1010);
        #1;
        rst_n = 1'b1;
        tick();
        checkOutput("post_reset_grant", 4'b0010, 1'b1, 8'd4, '0);

        // Random traffic: sticky requests, lengths changing every cycle, rare resets.
        doReset();
        bus.req = '0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            logic [NREQ-1:0] r;
            r = bus.req;
            for (int b = 0; b < NREQ; b++) if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
            for (int j = 0; j < NREQ; j++)
                lens[j] = ($urandom_range(0, 19) == 0) ? CW'($urandom_range(10, 20)) : CW'($urandom_range(0, 5));
            applyStimulus(r);
            tick();
            checkModel($sformatf("random%0d", cyc));
            if ($urandom_range(0, 99) == 0) begin
                #2;
                rst_n = 1'b0;
                modelReset();
                #1;
                checkModel("random_reset");
                rst_n = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
